// File: rtl/keypad_score_entry.sv
// 4x4 keypad scanner with debounce and decimal score entry (0..MAX_VALUE, up to 3 digits).
// Presents the live entry as BCD and commits it as a 7-bit binary score on Enter.
module keypad_score_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_VALUE      = 100
) (
  input  logic       clk,
  input  logic       RST,
  output logic [3:0] KEY_COL,
  input  logic [3:0] KEY_ROW,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic [1:0] digit_cnt,
  output logic [6:0] score_out,
  output logic       score_valid,
  output logic       err
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_TGT   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [10:0]       MAX_T     = 11'(MAX_VALUE);

  localparam logic [3:0] CODE_CLR   = 4'd3;
  localparam logic [3:0] CODE_BKSP  = 4'd7;
  localparam logic [3:0] CODE_ENTER = 4'd14;
  localparam logic [3:0] NOT_DIGIT  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_HELD} state_t;

  function automatic logic [3:0] key_digit(input logic [3:0] code);
    case (code)
      4'd0:    key_digit = 4'd1;
      4'd1:    key_digit = 4'd2;
      4'd2:    key_digit = 4'd3;
      4'd4:    key_digit = 4'd4;
      4'd5:    key_digit = 4'd5;
      4'd6:    key_digit = 4'd6;
      4'd8:    key_digit = 4'd7;
      4'd9:    key_digit = 4'd8;
      4'd10:   key_digit = 4'd9;
      4'd13:   key_digit = 4'd0;
      default: key_digit = NOT_DIGIT;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input logic [6:0] v);
    to_bcd = {4'(v / 7'd100), 4'((v / 7'd10) % 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [15:0]       seen_q, seen_d;
  logic              slot_end, scan_done, one_key;
  logic [15:0]       scan_bits;
  logic [3:0]        scan_code;

  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;

  logic [6:0]        value_q, value_d;
  logic [1:0]        dc_q, dc_d;
  logic [6:0]        score_q, score_d;
  logic              sv_q, sv_d;
  logic              err_q, err_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [3:0]        dig;
  logic [10:0]       t_sum;

  // Column scanner: each slot's rows are merged into a 16-bit map indexed row*4+col
  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    scan_done = slot_end && (col_q == 2'd3);
    slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);
    col_d     = slot_end ? col_q + 2'd1 : col_q;
    scan_bits = seen_q;
    for (int r = 0; r < 4; r++) begin
      if (slot_end && row_s2_q[r]) scan_bits[4*r + int'(col_q)] = 1'b1;
    end
    seen_d    = scan_done ? '0 : scan_bits;
    one_key   = scan_done && (scan_bits != 16'd0) &&
                ((scan_bits & (scan_bits - 16'd1)) == 16'd0);
    scan_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_bits[i]) scan_code = 4'(i);
    end
  end

  // Debounce FSM: next state. Multi-key scans fall into the !one_key path like NONE.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (scan_done) begin
      case (state_q)
        S_IDLE: begin
          if (one_key) begin
            cand_d = scan_code;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              state_d = S_CAND;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        S_CAND: begin
          if (!one_key) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (scan_code != cand_q) begin
            cand_d = scan_code;
            cnt_d  = CNT_W'(1);
          end else if (cnt_inc == CNT_TGT) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_HELD: begin
          if (one_key) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_TGT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Debounce FSM: outputs
  always_comb begin
    key_valid_d = scan_done && one_key &&
                  (((state_q == S_IDLE) && (DEBOUNCE_SCANS <= 1)) ||
                   ((state_q == S_CAND) && (scan_code == cand_q) && (cnt_inc == CNT_TGT)));
    key_code_d  = key_valid_d ? scan_code : key_code_q;
  end

  // Entry update, one cycle after the accepted key pulse
  always_comb begin
    value_d = value_q;
    dc_d    = dc_q;
    score_d = score_q;
    sv_d    = 1'b0;
    err_d   = 1'b0;
    dig     = key_digit(key_code_q);
    t_sum   = 11'(value_q) * 11'd10 + {7'd0, dig};
    bcd_d   = to_bcd(value_q);
    if (key_valid_q) begin
      if (dig != NOT_DIGIT) begin
        if ((dc_q == 2'd3) || (t_sum > MAX_T)) begin
          err_d = 1'b1;
        end else begin
          value_d = t_sum[6:0];
          dc_d    = dc_q + 2'd1;
        end
      end else begin
        case (key_code_q)
          CODE_CLR: begin
            value_d = '0;
            dc_d    = '0;
          end
          CODE_BKSP: begin
            if (dc_q == 2'd0) begin
              err_d = 1'b1;
            end else begin
              value_d = value_q / 7'd10;
              dc_d    = dc_q - 2'd1;
            end
          end
          CODE_ENTER: begin
            if (dc_q == 2'd0) begin
              err_d = 1'b1;
            end else begin
              score_d = value_q;
              sv_d    = 1'b1;
              value_d = '0;
              dc_d    = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      slot_q      <= '0;
      col_q       <= '0;
      seen_q      <= '0;
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      value_q     <= '0;
      dc_q        <= '0;
      score_q     <= '0;
      sv_q        <= 1'b0;
      err_q       <= 1'b0;
      bcd_q       <= '0;
    end else begin
      row_s1_q    <= KEY_ROW;
      row_s2_q    <= row_s1_q;
      slot_q      <= slot_d;
      col_q       <= col_d;
      seen_q      <= seen_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      value_q     <= value_d;
      dc_q        <= dc_d;
      score_q     <= score_d;
      sv_q        <= sv_d;
      err_q       <= err_d;
      bcd_q       <= bcd_d;
    end
  end

  assign KEY_COL      = 4'b0001 << col_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign bcd_hundreds = bcd_q[11:8];
  assign bcd_tens     = bcd_q[7:4];
  assign bcd_units    = bcd_q[3:0];
  assign digit_cnt    = dc_q;
  assign score_out    = score_q;
  assign score_valid  = sv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_keypad_score_entry.sv
// Directed bench for keypad_score_entry: a keypad model driven by a 16-bit pressed-key mask,
// a table of press vectors with hand-computed results, and hand-written reset/scan sequences.
module tb_keypad_score_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_col, key_row;
  logic       key_valid, score_valid, err;
  logic [3:0] key_code, bcd_h, bcd_t, bcd_u;
  logic [1:0] digit_cnt;
  logic [6:0] score_out;
  logic [15:0] mask = 16'h0000;

  int n_pass = 0;
  int n_total = 0;
  int kv_n = 0;
  int er_n = 0;
  int sv_n = 0;

  keypad_score_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .MAX_VALUE(100)) dut (
    .clk(clk), .RST(rst), .KEY_COL(key_col), .KEY_ROW(key_row),
    .key_valid(key_valid), .key_code(key_code),
    .bcd_hundreds(bcd_h), .bcd_tens(bcd_t), .bcd_units(bcd_u),
    .digit_cnt(digit_cnt), .score_out(score_out),
    .score_valid(score_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) connects column c to row r
  always_comb begin
    for (int r = 0; r < 4; r++) key_row[r] = |(mask[4*r +: 4] & key_col);
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1)   kv_n++;
    if (err === 1'b1)         er_n++;
    if (score_valid === 1'b1) sv_n++;
  end

  typedef struct {
    logic [15:0] mask;
    int hold;
    int kv;
    int code;
    int er;
    int sv;
    int bcd;
    int dc;
    int score;
  } vec_t;

  vec_t vecs[33];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " KEY_COL"}, int'(key_col), 1);
    chk({tag, " key_valid"}, int'(key_valid), 0);
    chk({tag, " key_code"}, int'(key_code), 0);
    chk({tag, " bcd"}, int'({bcd_h, bcd_t, bcd_u}), 0);
    chk({tag, " digit_cnt"}, int'(digit_cnt), 0);
    chk({tag, " score_out"}, int'(score_out), 0);
    chk({tag, " score_valid"}, int'(score_valid), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  initial begin
    int kv0, er0, sv0, first, dc32, dc33, u33, u34;

    // mask, hold cycles, kv pulses, key_code, err pulses, sv pulses, bcd, digit_cnt, score_out
    vecs[0]  = '{16'h0010, 96, 1,  4, 0, 0, 'h004, 1,   0}; // 4
    vecs[1]  = '{16'h0002, 96, 1,  1, 0, 0, 'h042, 2,   0}; // 2
    vecs[2]  = '{16'h4000, 96, 1, 14, 0, 1, 'h000, 0,  42}; // ENTER
    vecs[3]  = '{16'h0001, 96, 1,  0, 0, 0, 'h001, 1,  42}; // 1
    vecs[4]  = '{16'h2000, 96, 1, 13, 0, 0, 'h010, 2,  42}; // 0
    vecs[5]  = '{16'h2000, 96, 1, 13, 0, 0, 'h100, 3,  42}; // 0
    vecs[6]  = '{16'h0001, 96, 1,  0, 1, 0, 'h100, 3,  42}; // 1: fourth digit
    vecs[7]  = '{16'h4000, 96, 1, 14, 0, 1, 'h000, 0, 100}; // ENTER
    vecs[8]  = '{16'h0001, 96, 1,  0, 0, 0, 'h001, 1, 100}; // 1
    vecs[9]  = '{16'h0020, 96, 1,  5, 0, 0, 'h015, 2, 100}; // 5
    vecs[10] = '{16'h2000, 96, 1, 13, 1, 0, 'h015, 2, 100}; // 0: 150 > 100
    vecs[11] = '{16'h0080, 96, 1,  7, 0, 0, 'h001, 1, 100}; // BKSP
    vecs[12] = '{16'h0080, 96, 1,  7, 0, 0, 'h000, 0, 100}; // BKSP
    vecs[13] = '{16'h0080, 96, 1,  7, 1, 0, 'h000, 0, 100}; // BKSP on empty
    vecs[14] = '{16'h4000, 96, 1, 14, 1, 0, 'h000, 0, 100}; // ENTER on empty
    vecs[15] = '{16'h0400, 96, 1, 10, 0, 0, 'h009, 1, 100}; // 9
    vecs[16] = '{16'h0800, 96, 1, 11, 0, 0, 'h009, 1, 100}; // ignored (r2,c3)
    vecs[17] = '{16'h1000, 96, 1, 12, 0, 0, 'h009, 1, 100}; // ignored (r3,c0)
    vecs[18] = '{16'h0008, 96, 1,  3, 0, 0, 'h000, 0, 100}; // CLR
    vecs[19] = '{16'h0020, 16, 0,  3, 0, 0, 'h000, 0, 100}; // 5 for one scan only
    vecs[20] = '{16'h0020, 160, 1, 5, 0, 0, 'h005, 1, 100}; // 5 held 10 scans
    vecs[21] = '{16'h0003, 96, 0,  5, 0, 0, 'h005, 1, 100}; // 1+2 together
    vecs[22] = '{16'h0008, 96, 1,  3, 0, 0, 'h000, 0, 100}; // CLR
    vecs[23] = '{16'h2000, 96, 1, 13, 0, 0, 'h000, 1, 100}; // leading 0
    vecs[24] = '{16'h2000, 96, 1, 13, 0, 0, 'h000, 2, 100}; // leading 0
    vecs[25] = '{16'h0020, 96, 1,  5, 0, 0, 'h005, 3, 100}; // 5
    vecs[26] = '{16'h0001, 96, 1,  0, 1, 0, 'h005, 3, 100}; // 1: already 3 digits
    vecs[27] = '{16'h4000, 96, 1, 14, 0, 1, 'h000, 0,   5}; // ENTER
    vecs[28] = '{16'h0001, 96, 1,  0, 0, 0, 'h001, 1,   5}; // 1
    vecs[29] = '{16'h0002, 96, 1,  1, 0, 0, 'h012, 2,   5}; // 2
    vecs[30] = '{16'h0100, 96, 1,  8, 1, 0, 'h012, 2,   5}; // 7: 127 > 100
    vecs[31] = '{16'h0008, 96, 1,  3, 0, 0, 'h000, 0,   5}; // CLR
    vecs[32] = '{16'h0100, 96, 1,  8, 0, 0, 'h007, 1,   5}; // 7

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("init");

    // Idle scan: one column per 4 clocks
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("idle KEY_COL c%0d", i), int'(key_col), 1 << (i / 4));
      step(1);
    end
    step(48);
    chk("idle key_valid pulses", kv_n, 0);
    chk("idle err pulses", er_n, 0);
    chk("idle score_valid pulses", sv_n, 0);
    chk("idle bcd", int'({bcd_h, bcd_t, bcd_u}), 0);

    for (int i = 0; i < 33; i++) begin
      kv0 = kv_n;
      er0 = er_n;
      sv0 = sv_n;
      mask = vecs[i].mask;
      step(vecs[i].hold);
      mask = 16'h0000;
      step(96);
      chk($sformatf("v%0d key_valid pulses", i), kv_n - kv0, vecs[i].kv);
      chk($sformatf("v%0d key_code", i), int'(key_code), vecs[i].code);
      chk($sformatf("v%0d err pulses", i), er_n - er0, vecs[i].er);
      chk($sformatf("v%0d score_valid pulses", i), sv_n - sv0, vecs[i].sv);
      chk($sformatf("v%0d bcd", i), int'({bcd_h, bcd_t, bcd_u}), vecs[i].bcd);
      chk($sformatf("v%0d digit_cnt", i), int'(digit_cnt), vecs[i].dc);
      chk($sformatf("v%0d score_out", i), int'(score_out), vecs[i].score);
    end

    // Hold 3, then reset while it is still held
    mask = 16'h0004;
    step(96);
    chk("pre-rst digit_cnt", int'(digit_cnt), 2);
    chk("pre-rst bcd", int'({bcd_h, bcd_t, bcd_u}), 'h073);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset_outputs("mid-rst");

    // Key 3 (col 2) is first seen in the scan ending at cycle 15, accepted at cycle 31
    first = -1;
    dc32 = -1;
    dc33 = -1;
    u33 = -1;
    u34 = -1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (key_valid && first < 0) first = c;
      if (c == 32) dc32 = int'(digit_cnt);
      if (c == 33) begin
        dc33 = int'(digit_cnt);
        u33  = int'(bcd_u);
      end
      if (c == 34) u34 = int'(bcd_u);
    end
    chk("post-rst key_valid cycle", first, 32);
    chk("post-rst key_code", int'(key_code), 2);
    chk("post-rst digit_cnt at N+1", dc32, 0);
    chk("post-rst digit_cnt at N+2", dc33, 1);
    chk("post-rst bcd_units at N+2", u33, 0);
    chk("post-rst bcd_units at N+3", u34, 3);
    mask = 16'h0000;
    step(96);
    chk("final bcd", int'({bcd_h, bcd_t, bcd_u}), 'h003);
    chk("final score_out", int'(score_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
